// File: rtl/fifo_pkg.sv
// Shared sizing for the async FIFO write path: default widths and the
// helpers that derive the beat-to-word packing ratio.
package fifo_pkg;
  localparam int FIFO_DW = 16;
  localparam int FIFO_AW = 8;

  function automatic int ratio_f(input int dw, input int iw);
    return dw / iw;
  endfunction

  function automatic int lw_f(input int dw, input int iw);
    return $clog2(dw / iw);
  endfunction

  // Packing only works on whole lanes and a lane index that wraps naturally.
  function automatic bit ratio_ok(input int dw, input int iw);
    int r;
    r = dw / iw;
    return (dw % iw == 0) && (r >= 2) && ((r & (r - 1)) == 0);
  endfunction
endpackage

// File: rtl/fifo_wr_packer_if.sv
// Narrow upstream beat stream plus the FIFO write port seen by the packer.
interface fifo_wr_packer_if import fifo_pkg::*; #(
  parameter int DW = FIFO_DW,
  parameter int IW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_data;
  logic          in_last;
  logic          wfull;
  logic          winc;
  logic [DW-1:0] wdata;

  modport master (output in_valid, in_data, in_last, wfull,
                  input  in_ready, winc, wdata);
  modport slave  (input  in_valid, in_data, in_last, wfull,
                  output in_ready, winc, wdata);
endinterface

// File: rtl/fifo_lane_acc.sv
// Little-endian lane accumulator: collects IW-bit beats into a DW-bit word,
// zero-padding the unfilled upper lanes when a packet ends early.
module fifo_lane_acc import fifo_pkg::*; #(
  parameter int DW = FIFO_DW,
  parameter int IW = 8,
  localparam int RATIO = ratio_f(DW, IW),
  localparam int LW = lw_f(DW, IW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          accept,
  input  logic [IW-1:0] data,
  input  logic          last,
  output logic          word_done,
  output logic [DW-1:0] word,
  output logic [LW-1:0] lane
);
  logic [DW-1:0] acc;

  assign word_done = accept && ((lane == LW'(RATIO - 1)) || last);

  // Lanes below the current one come from acc, the current lane from the beat,
  // everything above is forced to zero.
  always_comb begin
    word = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (k < int'(lane))
        word[k*IW +: IW] = acc[k*IW +: IW];
      else if (k == int'(lane))
        word[k*IW +: IW] = data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      lane <= '0;
    end else if (accept) begin
      if (word_done) begin
        acc  <= '0;
        lane <= '0;
      end else begin
        acc  <= word;
        lane <= lane + LW'(1);
      end
    end
  end
endmodule

// File: rtl/fifo_wr_packer.sv
// Write-clock-domain packer: narrow beats in, one FIFO word per RATIO beats
// (or per packet end) out, with a single holding register absorbing wfull.
module fifo_wr_packer import fifo_pkg::*; #(
  parameter int DW = FIFO_DW,
  parameter int IW = 8,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_wr_packer_if.slave      bus,
  output logic [CW-1:0]        word_cnt,
  output logic                 busy
);
  localparam int LW = lw_f(DW, IW);

  if (!ratio_ok(DW, IW)) begin : g_bad_ratio
    $error("fifo_wr_packer: DW/IW must be an integer power of two >= 2");
  end

  logic          accept;
  logic          word_done;
  logic [DW-1:0] word;
  logic [LW-1:0] lane;
  logic [DW-1:0] out_reg;
  logic          out_valid;

  // A held word can only be blocked by wfull, and then no beat is accepted,
  // so a completing beat always finds the holding register free or draining.
  assign bus.in_ready = !out_valid || !bus.wfull;
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.winc     = out_valid && !bus.wfull;
  assign bus.wdata    = out_reg;
  assign busy         = out_valid || (lane != '0);

  fifo_lane_acc #(.DW(DW), .IW(IW)) u_lane_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .accept    (accept),
    .data      (bus.in_data),
    .last      (bus.in_last),
    .word_done (word_done),
    .word      (word),
    .lane      (lane)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg   <= '0;
      out_valid <= 1'b0;
      word_cnt  <= '0;
    end else begin
      if (word_done) begin
        out_reg   <= word;
        out_valid <= 1'b1;
      end else if (bus.winc) begin
        out_valid <= 1'b0;
      end
      if (bus.winc && (word_cnt != '1))
        word_cnt <= word_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_fifo_wr_packer.sv
// Scenario bench for fifo_wr_packer: a 16/8 instance for function and
// backpressure, and a CW=2 instance for counter saturation.
module tb_fifo_wr_packer;
  logic        clk;
  logic        rst_n;
  logic [15:0] word_cnt;
  logic        busy;
  logic [1:0]  word_cnt2;
  logic        busy2;

  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_w;

  fifo_wr_packer_if #(.DW(16), .IW(8)) bus ();
  fifo_wr_packer_if #(.DW(16), .IW(8)) bus2 ();

  fifo_wr_packer #(.DW(16), .IW(8), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .word_cnt(word_cnt), .busy(busy));
  fifo_wr_packer #(.DW(16), .IW(8), .CW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .word_cnt(word_cnt2), .busy(busy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (bus.winc !== 1'b0) begin n_fail++; $display("FAIL reset_winc: got %b expected 0", bus.winc); end
    n_checks++; if (bus.wdata !== 16'h0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0000", bus.wdata); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (word_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_word_cnt: got %0d expected 0", word_cnt); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_word();
    exp_q.push_back(16'hBBAA);
    beat(8'hAA, 1'b0);
    tick();
    n_checks++; if (bus.winc !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_half: winc=%b busy=%b expected winc=0 busy=1", bus.winc, busy); end
    beat(8'hBB, 1'b0);
    tick();
    idle();
    exp_w = exp_q.pop_front();
    n_checks++; if (bus.winc !== 1'b1 || bus.wdata !== exp_w) begin n_fail++; $display("FAIL single_write: winc=%b wdata=%h expected winc=1 wdata=%h", bus.winc, bus.wdata, exp_w); end
    exp_cnt++;
    tick();
    n_checks++; if (word_cnt !== 16'(exp_cnt) || bus.winc !== 1'b0) begin n_fail++; $display("FAIL single_cnt: word_cnt=%0d winc=%b expected %0d and 0", word_cnt, bus.winc, exp_cnt); end
  endtask

  task automatic test_short_packet();
    exp_q.push_back(16'h005C);
    beat(8'h5C, 1'b1);
    tick();
    idle();
    exp_w = exp_q.pop_front();
    n_checks++; if (bus.winc !== 1'b1 || bus.wdata !== exp_w) begin n_fail++; $display("FAIL short_write: winc=%b wdata=%h expected winc=1 wdata=%h", bus.winc, bus.wdata, exp_w); end
    exp_cnt++;
    tick();
    n_checks++; if (busy !== 1'b0 || bus.winc !== 1'b0) begin n_fail++; $display("FAIL short_idle: busy=%b winc=%b expected 0 0", busy, bus.winc); end
    n_checks++; if (word_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL short_cnt: got %0d expected %0d", word_cnt, exp_cnt); end
  endtask

  task automatic test_backpressure();
    exp_q.push_back(16'h2211);
    bus.wfull = 1'b1;
    beat(8'h11, 1'b0);
    tick();
    beat(8'h22, 1'b0);
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.winc !== 1'b0 || bus.wdata !== 16'h2211 || bus.in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_stall[%0d]: winc=%b wdata=%h in_ready=%b expected 0 2211 0", i, bus.winc, bus.wdata, bus.in_ready); end
      if (i < 4) tick();
    end
    bus.wfull = 1'b0;
    #1;
    exp_w = exp_q.pop_front();
    n_checks++; if (bus.winc !== 1'b1 || bus.wdata !== exp_w) begin n_fail++; $display("FAIL bp_release: winc=%b wdata=%h expected winc=1 wdata=%h", bus.winc, bus.wdata, exp_w); end
    exp_cnt++;
    tick();
    n_checks++; if (bus.winc !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_after: winc=%b in_ready=%b expected 0 1", bus.winc, bus.in_ready); end
    n_checks++; if (word_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL bp_cnt: got %0d expected %0d", word_cnt, exp_cnt); end
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 8; i += 2) exp_q.push_back({8'(i + 1), 8'(i)});
    for (int i = 1; i <= 8; i++) begin
      beat(8'(i), 1'b0);
      tick();
      if (i % 2 == 0) begin
        exp_w = exp_q.pop_front();
        exp_cnt++;
        n_checks++; if (bus.winc !== 1'b1 || bus.wdata !== exp_w) begin n_fail++; $display("FAIL stream_write[%0d]: winc=%b wdata=%h expected winc=1 wdata=%h", i, bus.winc, bus.wdata, exp_w); end
      end else begin
        n_checks++; if (bus.winc !== 1'b0) begin n_fail++; $display("FAIL stream_gap[%0d]: winc=%b expected 0", i, bus.winc); end
      end
    end
    idle();
    tick();
    n_checks++; if (word_cnt !== 16'(exp_cnt) || bus.winc !== 1'b0) begin n_fail++; $display("FAIL stream_cnt: word_cnt=%0d winc=%b expected %0d 0", word_cnt, bus.winc, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) exp_q.push_back(16'(8'h91 + i));
    for (int i = 0; i < 3; i++) begin
      beat(8'(8'h91 + i), 1'b1);
      tick();
      exp_w = exp_q.pop_front();
      exp_cnt++;
      n_checks++; if (bus.winc !== 1'b1 || bus.wdata !== exp_w) begin n_fail++; $display("FAIL b2b_write[%0d]: winc=%b wdata=%h expected winc=1 wdata=%h", i, bus.winc, bus.wdata, exp_w); end
    end
    idle();
    tick();
    n_checks++; if (word_cnt !== 16'(exp_cnt) || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_cnt: word_cnt=%0d busy=%b expected %0d 0", word_cnt, busy, exp_cnt); end
  endtask

  task automatic test_reset_mid_packet();
    beat(8'h77, 1'b0);
    tick();
    idle();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    n_checks++; if (bus.winc !== 1'b0 || busy !== 1'b0 || word_cnt !== 16'd0 || bus.wdata !== 16'h0) begin
      n_fail++; $display("FAIL midrst_async: winc=%b busy=%b word_cnt=%0d wdata=%h expected 0 0 0 0000", bus.winc, busy, word_cnt, bus.wdata); end
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back(16'h2010);
    beat(8'h10, 1'b0);
    tick();
    beat(8'h20, 1'b0);
    tick();
    idle();
    exp_w = exp_q.pop_front();
    n_checks++; if (bus.winc !== 1'b1 || bus.wdata !== exp_w) begin n_fail++; $display("FAIL midrst_write: winc=%b wdata=%h expected winc=1 wdata=%h", bus.winc, bus.wdata, exp_w); end
    exp_cnt++;
    tick();
    n_checks++; if (word_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL midrst_cnt: got %0d expected %0d", word_cnt, exp_cnt); end
  endtask

  task automatic test_saturation();
    int writes;
    writes = 0;
    for (int i = 0; i < 5; i++) exp_q.push_back(16'(8'hC0 + i));
    for (int i = 0; i < 5; i++) begin
      bus2.in_valid = 1'b1;
      bus2.in_data  = 8'(8'hC0 + i);
      bus2.in_last  = 1'b1;
      tick();
      exp_w = exp_q.pop_front();
      n_checks++; if (bus2.winc !== 1'b1 || bus2.wdata !== exp_w) begin n_fail++; $display("FAIL sat_write[%0d]: winc=%b wdata=%h expected winc=1 wdata=%h", i, bus2.winc, bus2.wdata, exp_w); end
      n_checks++; if (word_cnt2 !== 2'((writes > 3) ? 3 : writes)) begin n_fail++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, word_cnt2, (writes > 3) ? 3 : writes); end
      writes++;
    end
    bus2.in_valid = 1'b0;
    bus2.in_last  = 1'b0;
    tick();
    n_checks++; if (word_cnt2 !== 2'd3) begin n_fail++; $display("FAIL sat_final: got %0d expected 3", word_cnt2); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    bus.wfull     = 1'b0;
    bus2.in_valid = 1'b0;
    bus2.in_data  = 8'h00;
    bus2.in_last  = 1'b0;
    bus2.wfull    = 1'b0;
    repeat (3) tick();
    test_reset();
    test_single_word();
    test_short_packet();
    test_backpressure();
    test_streaming();
    test_back_to_back();
    test_reset_mid_packet();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
